eth_avalon_txbd_fetch: RTL and testbench

//  TX buffer-descriptor scanner that sits downstream of the BD RAM.

---
 rtl/eth_avalon_txbd_fetch_if.sv | 45 ++++
 rtl/eth_avalon_txbd_fetch.sv | 183 ++++++++++++++++++
 tb/tb_eth_avalon_txbd_fetch.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_avalon_txbd_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : eth_avalon_txbd_fetch_if
// Description : BD RAM port plus TX DMA descriptor/completion channel used by
//               the TX buffer-descriptor scanner. The master is the scanner,
//               the slave is the RAM/DMA side.
// Revision    : 1.0  initial release
// ============================================================================
interface eth_avalon_txbd_fetch_if #(
    parameter int AW = 8
) ();
    // BD RAM port
    logic [AW-1:0] bd_address;
    logic          bd_wren;
    logic [31:0]   bd_wdata;
    logic [31:0]   bd_rdata;

    // Descriptor offer to the TX DMA
    logic          desc_valid;
    logic          desc_ready;
    logic [15:0]   desc_len;
    logic [31:0]   desc_ptr;
    logic [2:0]    desc_flags;

    // Completion from the TX DMA
    logic          done_valid;
    logic [8:0]    done_status;

    modport master (
        output bd_address, bd_wren, bd_wdata,
        input  bd_rdata,
        output desc_valid, desc_len, desc_ptr, desc_flags,
        input  desc_ready,
        input  done_valid, done_status
    );

    modport slave (
        input  bd_address, bd_wren, bd_wdata,
        output bd_rdata,
        input  desc_valid, desc_len, desc_ptr, desc_flags,
        output desc_ready,
        output done_valid, done_status
    );
endinterface
`default_nettype wire

// File: rtl/eth_avalon_txbd_fetch.sv
`default_nettype none
// ============================================================================
// Module      : eth_avalon_txbd_fetch
// Description : TX buffer-descriptor scanner. Walks TX BDs in ring order,
//               reads ctrl/ptr words from the BD RAM, offers ready BDs to the
//               TX DMA, writes completion status back and pulses irq_txb.
// Revision    : 1.0  initial release
// ============================================================================
module eth_avalon_txbd_fetch #(
    parameter int DEPTH       = 128,
    parameter int POLL_CYCLES = 16
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    tx_en,
    input  logic [7:0]              tx_bd_num,
    output logic                    irq_txb,
    output logic [6:0]              cur_bd,
    eth_avalon_txbd_fetch_if.master bus
);

    localparam int c_AW        = $clog2(DEPTH - 1) + 1;
    localparam int c_MAX_BD    = DEPTH / 2;
    localparam int c_CW        = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam logic [c_CW-1:0] c_POLL_LOAD = c_CW'(POLL_CYCLES - 1);

    localparam logic [3:0] c_IDLE     = 4'd0;
    localparam logic [3:0] c_RD_CTRL  = 4'd1;
    localparam logic [3:0] c_CHK_CTRL = 4'd2;
    localparam logic [3:0] c_RD_PTR   = 4'd3;
    localparam logic [3:0] c_LAT_PTR  = 4'd4;
    localparam logic [3:0] c_OFFER    = 4'd5;
    localparam logic [3:0] c_BUSY     = 4'd6;
    localparam logic [3:0] c_WB       = 4'd7;
    localparam logic [3:0] c_NEXT     = 4'd8;
    localparam logic [3:0] c_POLL     = 4'd9;

    logic [3:0]       r_state;
    logic [6:0]       r_idx;
    logic [c_CW-1:0]  r_poll_cnt;
    logic [c_AW-1:0]  r_bd_address;
    logic             r_bd_wren;
    logic [31:0]      r_bd_wdata;
    logic             r_desc_valid;
    logic [15:0]      r_desc_len;
    logic [31:0]      r_desc_ptr;
    logic [5:0]       r_ctrl_bits;   // ctrl[14:9]: IRQ, WR, PAD, CRC, 2 reserved
    logic             r_irq_txb;

    logic [7:0]       w_bd_num;
    logic [7:0]       w_idx_inc;
    logic [6:0]       w_idx_next;
    logic [c_AW-1:0]  w_ctrl_addr;
    logic [c_AW-1:0]  w_ptr_addr;
    logic [31:0]      w_wb_data;

    // Clamp BD count, compute ring successor, addresses and write-back word
    always_comb begin
        w_bd_num    = (tx_bd_num > 8'(c_MAX_BD)) ? 8'(c_MAX_BD) : tx_bd_num;
        w_idx_inc   = {1'b0, r_idx} + 8'd1;
        // Wrap on WR, on the last BD, or when the count shrank below idx+1
        w_idx_next  = (r_ctrl_bits[4] || (w_idx_inc >= w_bd_num)) ? 7'd0 : (r_idx + 7'd1);
        w_ctrl_addr = c_AW'({r_idx, 1'b0});
        w_ptr_addr  = c_AW'({r_idx, 1'b1});
        // RD cleared, IRQ/WR/PAD/CRC kept, status replaces the low 9 bits
        w_wb_data   = {r_desc_len, 1'b0, r_ctrl_bits, bus.done_status};
    end

    // Scanner state machine with registered RAM and DMA outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= c_IDLE;
            r_idx        <= 7'd0;
            r_poll_cnt   <= '0;
            r_bd_address <= '0;
            r_bd_wren    <= 1'b0;
            r_bd_wdata   <= 32'd0;
            r_desc_valid <= 1'b0;
            r_desc_len   <= 16'd0;
            r_desc_ptr   <= 32'd0;
            r_ctrl_bits  <= 6'd0;
            r_irq_txb    <= 1'b0;
        end else begin
            r_bd_wren <= 1'b0;
            r_irq_txb <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (tx_en && (w_bd_num != 8'd0)) begin
                        r_state      <= c_RD_CTRL;
                        r_bd_address <= w_ctrl_addr;
                    end
                end
                c_RD_CTRL: begin
                    r_state <= tx_en ? c_CHK_CTRL : c_IDLE;
                end
                c_CHK_CTRL: begin
                    if (!tx_en) begin
                        r_state <= c_IDLE;
                    end else begin
                        r_desc_len  <= bus.bd_rdata[31:16];
                        r_ctrl_bits <= bus.bd_rdata[14:9];
                        if (bus.bd_rdata[15]) begin
                            r_state      <= c_RD_PTR;
                            r_bd_address <= w_ptr_addr;
                        end else begin
                            r_state    <= c_POLL;
                            r_poll_cnt <= c_POLL_LOAD;
                        end
                    end
                end
                c_RD_PTR: begin
                    r_state <= tx_en ? c_LAT_PTR : c_IDLE;
                end
                c_LAT_PTR: begin
                    if (!tx_en) begin
                        r_state <= c_IDLE;
                    end else begin
                        r_desc_ptr   <= bus.bd_rdata;
                        r_desc_valid <= 1'b1;
                        r_state      <= c_OFFER;
                    end
                end
                c_OFFER: begin
                    // A handshake completing in the same cycle as tx_en
                    // falling has already transferred the BD, so it wins
                    if (bus.desc_ready) begin
                        r_desc_valid <= 1'b0;
                        r_state      <= c_BUSY;
                    end else if (!tx_en) begin
                        r_desc_valid <= 1'b0;
                        r_state      <= c_IDLE;
                    end
                end
                c_BUSY: begin
                    if (bus.done_valid) begin
                        r_bd_wren    <= 1'b1;
                        r_bd_address <= w_ctrl_addr;
                        r_bd_wdata   <= w_wb_data;
                        r_irq_txb    <= r_ctrl_bits[5];
                        r_state      <= c_WB;
                    end
                end
                c_WB: begin
                    r_state <= c_NEXT;
                end
                c_NEXT: begin
                    r_idx <= w_idx_next;
                    if (tx_en && (w_bd_num != 8'd0)) begin
                        r_state      <= c_RD_CTRL;
                        r_bd_address <= c_AW'({w_idx_next, 1'b0});
                    end else begin
                        r_state <= c_IDLE;
                    end
                end
                c_POLL: begin
                    if (!tx_en) begin
                        r_state <= c_IDLE;
                    end else if (r_poll_cnt == '0) begin
                        r_state      <= c_RD_CTRL;
                        r_bd_address <= w_ctrl_addr;
                    end else begin
                        r_poll_cnt <= r_poll_cnt - c_CW'(1);
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign bus.bd_address  = r_bd_address;
    assign bus.bd_wren     = r_bd_wren;
    assign bus.bd_wdata    = r_bd_wdata;
    assign bus.desc_valid  = r_desc_valid;
    assign bus.desc_len    = r_desc_len;
    assign bus.desc_ptr    = r_desc_ptr;
    assign bus.desc_flags  = {r_ctrl_bits[3], r_ctrl_bits[2], r_ctrl_bits[5]};
    assign irq_txb         = r_irq_txb;
    assign cur_bd          = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_eth_avalon_txbd_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_eth_avalon_txbd_fetch
// Description : Self-checking bench for the TX BD scanner: BD RAM model,
//               DMA responder and a transaction-level ring model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_eth_avalon_txbd_fetch;

    localparam int c_DEPTH = 128;
    localparam int c_POLL  = 16;
    localparam int c_AW    = 8;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       tx_en;
    logic [7:0] tx_bd_num;
    logic       irq_txb;
    logic [6:0] cur_bd;

    eth_avalon_txbd_fetch_if #(.AW(c_AW)) bus ();

    eth_avalon_txbd_fetch #(
        .DEPTH       (c_DEPTH),
        .POLL_CYCLES (c_POLL)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .tx_en     (tx_en),
        .tx_bd_num (tx_bd_num),
        .irq_txb   (irq_txb),
        .cur_bd    (cur_bd),
        .bus       (bus)
    );

    always #5 clock = ~clock;

    // BD RAM contents as software sees them; only the bench writes here
    logic [31:0] mem [0:c_DEPTH-1];
    int          cyc = 0;

    // Registered-read RAM model and cycle counter
    always @(posedge clock) begin
        cyc          <= cyc + 1;
        bus.bd_rdata <= mem[bus.bd_address[6:0]];
    end

    int n_compared   = 0;
    int n_mismatched = 0;
    int wren_cnt     = 0;
    int irq_cnt      = 0;
    int n_wb         = 0;
    int n_irq        = 0;

    // Count every RAM write and IRQ pulse the DUT produces
    always @(negedge clock) begin
        if (bus.bd_wren) wren_cnt <= wren_cnt + 1;
        if (irq_txb)     irq_cnt  <= irq_cnt + 1;
    end

    int          m_idx      = 0;
    bit          rearm      = 1'b0;
    bit          allow_wr   = 1'b0;
    int          offer_cyc  = 0;
    logic [31:0] last_wdata = 32'd0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_addr"},  64'(bus.bd_address), 64'd0);
        check_eq({tag, "_wren"},  64'(bus.bd_wren),    64'd0);
        check_eq({tag, "_wdata"}, 64'(bus.bd_wdata),   64'd0);
        check_eq({tag, "_valid"}, 64'(bus.desc_valid), 64'd0);
        check_eq({tag, "_len"},   64'(bus.desc_len),   64'd0);
        check_eq({tag, "_ptr"},   64'(bus.desc_ptr),   64'd0);
        check_eq({tag, "_flags"}, 64'(bus.desc_flags), 64'd0);
        check_eq({tag, "_irq"},   64'(irq_txb),        64'd0);
        check_eq({tag, "_curbd"}, 64'(cur_bd),         64'd0);
    endtask

    function automatic logic [31:0] rand_ctrl(input bit wr_ok);
        logic [31:0] c;
        c     = $urandom;
        c[15] = 1'b1;
        c[13] = wr_ok && ($urandom_range(0, 7) == 0);
        return c;
    endfunction

    // Called at a negedge; waits (bounded) for an offer
    task automatic wait_offer(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (bus.desc_valid) begin
                ok        = 1'b1;
                offer_cyc = cyc;
                break;
            end
            @(negedge clock);
        end
    endtask

    // One full BD transaction against the ring model
    task automatic serve_bd(input logic [8:0] status, input int hold, input int gap,
                            input logic [7:0] new_num);
        bit          ok;
        logic [31:0] ctrl;
        logic [31:0] ptr;
        logic [31:0] wb;
        int          eff;
        int          nxt;
        wait_offer(ok);
        check_eq("offer_seen", 64'(ok), 64'd1);
        if (!ok) return;
        ctrl = mem[2*m_idx];
        ptr  = mem[2*m_idx+1];
        check_eq("cur_bd",     64'(cur_bd),         64'(m_idx));
        check_eq("desc_len",   64'(bus.desc_len),   64'(ctrl[31:16]));
        check_eq("desc_ptr",   64'(bus.desc_ptr),   64'(ptr));
        check_eq("desc_flags", 64'(bus.desc_flags), 64'({ctrl[12], ctrl[11], ctrl[14]}));
        for (int i = 0; i < hold; i++) begin
            bus.done_valid  = ($urandom_range(0, 3) == 0);
            bus.done_status = 9'($urandom);
            @(negedge clock);
            bus.done_valid = 1'b0;
            check_eq("hold_valid", 64'(bus.desc_valid), 64'd1);
            check_eq("hold_len",   64'(bus.desc_len),   64'(ctrl[31:16]));
            check_eq("hold_ptr",   64'(bus.desc_ptr),   64'(ptr));
            check_eq("hold_addr",  64'(bus.bd_address), 64'(2*m_idx+1));
        end
        bus.desc_ready = 1'b1;
        @(negedge clock);
        bus.desc_ready = 1'b0;
        check_eq("drop_valid", 64'(bus.desc_valid), 64'd0);
        tx_bd_num = new_num;
        repeat (gap) @(negedge clock);
        wb = {ctrl[31:16], 1'b0, ctrl[14:9], status};
        bus.done_valid  = 1'b1;
        bus.done_status = status;
        @(negedge clock);
        bus.done_valid = 1'b0;
        check_eq("wb_wren", 64'(bus.bd_wren),    64'd1);
        check_eq("wb_addr", 64'(bus.bd_address), 64'(2*m_idx));
        check_eq("wb_data", 64'(bus.bd_wdata),   64'(wb));
        check_eq("wb_irq",  64'(irq_txb),        64'(ctrl[14]));
        last_wdata = bus.bd_wdata;
        n_wb++;
        if (ctrl[14]) n_irq++;
        if (rearm) begin
            mem[2*m_idx]   = rand_ctrl(allow_wr);
            mem[2*m_idx+1] = $urandom;
        end else begin
            mem[2*m_idx] = wb;
        end
        eff = (tx_bd_num > 8'd64) ? 64 : int'(tx_bd_num);
        nxt = m_idx + 1;
        if (ctrl[13] || nxt >= eff) nxt = 0;
        m_idx = nxt;
        if (tx_en && eff != 0) begin
            repeat (2) @(negedge clock);
            check_eq("next_addr",   64'(bus.bd_address), 64'(2*m_idx));
            check_eq("next_cur_bd", 64'(cur_bd),         64'(m_idx));
        end
    endtask

    initial begin
        bit ok;
        int c0;
        int cs;
        int s;
        int w0;
        int seen;
        int sel;
        logic [7:0] nn;

        for (int i = 0; i < c_DEPTH; i++) mem[i] = 32'd0;
        reset_n         = 1'b0;
        tx_en           = 1'b0;
        tx_bd_num       = 8'd0;
        bus.desc_ready  = 1'b0;
        bus.done_valid  = 1'b0;
        bus.done_status = 9'd0;
        repeat (3) @(negedge clock);
        check_idle_outputs("rst");
        reset_n = 1'b1;
        @(negedge clock);

        // Spec vector: BD0 offered and written back with status 0x1A5
        mem[0]    = 32'h0040_C000;
        mem[1]    = 32'h0000_1000;
        mem[2]    = 32'h0020_A800;   // BD1: RD, WR, CRC
        mem[3]    = 32'h0000_2000;
        tx_bd_num = 8'd2;
        tx_en     = 1'b1;
        c0        = cyc;
        serve_bd(9'h1A5, 3, 2, 8'd4);
        check_eq("t1_latency", 64'(offer_cyc), 64'(c0 + 5));
        check_eq("t1_wdata",   64'(last_wdata), 64'h0040_41A5);

        // BD1 with WR set wraps to BD0 although four BDs are configured
        serve_bd(9'($urandom), 1, 0, 8'd4);

        // BD0 now not ready: it is polled every POLL_CYCLES+2 clocks
        tx_en = 1'b0;
        repeat (3) @(negedge clock);
        check_eq("t3_idle_valid", 64'(bus.desc_valid), 64'd0);
        tx_en = 1'b1;
        c0    = cyc;
        repeat ($urandom_range(5, 60)) @(negedge clock);
        check_eq("t3_no_offer", 64'(bus.desc_valid), 64'd0);
        mem[1] = $urandom;
        mem[0] = rand_ctrl(1'b0);
        mem[3] = $urandom;
        mem[2] = rand_ctrl(1'b0);
        cs     = cyc;
        s      = c0 + 2;
        while (s < cs + 1) s += c_POLL + 2;
        wait_offer(ok);
        check_eq("t3_offer", 64'(ok), 64'd1);
        check_eq("t3_poll_latency", 64'(offer_cyc), 64'(s + 3));
        serve_bd(9'($urandom), 0, 1, 8'd4);

        // Long stall on desc_ready, then tx_en withdraws the offer
        wait_offer(ok);
        check_eq("t4_offer", 64'(ok), 64'd1);
        w0 = wren_cnt;
        repeat (10) @(negedge clock);
        check_eq("t4_valid", 64'(bus.desc_valid), 64'd1);
        check_eq("t4_len",   64'(bus.desc_len),   64'(mem[2][31:16]));
        check_eq("t4_ptr",   64'(bus.desc_ptr),   64'(mem[3]));
        check_eq("t4_addr",  64'(bus.bd_address), 64'd3);
        tx_en = 1'b0;
        @(negedge clock);
        check_eq("t4_withdraw", 64'(bus.desc_valid), 64'd0);
        repeat (20) @(negedge clock);
        check_eq("t4_idle_addr",  64'(bus.bd_address), 64'd3);
        check_eq("t4_idle_curbd", 64'(cur_bd),         64'd1);
        check_eq("t4_no_write",   64'(wren_cnt),       64'(w0));

        // Zero BDs configured: enabled but no traffic
        tx_bd_num = 8'd0;
        tx_en     = 1'b1;
        seen      = 0;
        repeat (30) begin
            @(negedge clock);
            if (bus.desc_valid) seen++;
        end
        check_eq("t5_no_offer", 64'(seen),           64'd0);
        check_eq("t5_addr",     64'(bus.bd_address), 64'd3);
        mem[4]    = rand_ctrl(1'b0);
        mem[5]    = $urandom;
        tx_bd_num = 8'd4;
        serve_bd(9'($urandom), 2, 1, 8'd4);

        // Asynchronous reset while the DMA owns BD2
        wait_offer(ok);
        check_eq("t6_offer", 64'(ok), 64'd1);
        bus.desc_ready = 1'b1;
        @(negedge clock);
        bus.desc_ready = 1'b0;
        check_eq("t6_curbd_busy", 64'(cur_bd), 64'd2);
        mem[0] = rand_ctrl(1'b0);
        mem[1] = $urandom;
        #2 reset_n = 1'b0;
        #1 check_idle_outputs("t6");
        @(negedge clock);
        reset_n = 1'b1;
        m_idx   = 0;
        serve_bd(9'($urandom), 1, 2, 8'd4);

        // Randomized ring traffic: full 64-BD ring first, then mixed counts
        rearm    = 1'b1;
        allow_wr = 1'b0;
        for (int i = 0; i < 64; i++) begin
            mem[2*i]   = rand_ctrl(1'b0);
            mem[2*i+1] = $urandom;
        end
        for (int t = 0; t < 70; t++) begin
            serve_bd(9'($urandom), $urandom_range(0, 3), $urandom_range(0, 4), 8'd200);
        end
        allow_wr = 1'b1;
        for (int t = 0; t < 60; t++) begin
            sel = $urandom_range(0, 2);
            if (sel == 0)      nn = 8'($urandom_range(1, 8));
            else if (sel == 1) nn = 8'($urandom_range(60, 255));
            else               nn = 8'd200;
            serve_bd(9'($urandom), $urandom_range(0, 3), $urandom_range(0, 4), nn);
        end

        repeat (5) @(negedge clock);
        check_eq("wb_count",  64'(wren_cnt), 64'(n_wb));
        check_eq("irq_count", 64'(irq_cnt),  64'(n_irq));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
`default_nettype wire
